// File: rtl/sc_spi_pkg.sv
// Shared definitions for the SPI engine transfer controller: FSM encodings
// and the frame-width helper.
package sc_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHK   = 3'd1,
    ST_START = 3'd2,
    ST_WBUSY = 3'd3,
    ST_WIDLE = 3'd4,
    ST_GUARD = 3'd5,
    ST_DONE  = 3'd6
  } xfer_state_e;

  localparam int unsigned WORD_W = 32;

  // 32-bit words occupied by one frame of (dwidth+1) bits
  function automatic logic [4:0] words_per_frame(input logic [8:0] dwidth);
    return {1'b0, dwidth[8:5]} + 5'd1;
  endfunction

endpackage

// File: rtl/sc_spi_bufram.sv
// 1W/1R word buffer; REG_RD selects an asynchronous read or a registered
// read whose output register clears on reset.
module sc_spi_bufram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DW     = 32,
  parameter bit          REG_RD = 1'b0,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          SPICLK,
  input  logic          SYSRSTB,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] radr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  generate
    if (REG_RD) begin : g_reg_rd
      logic [DW-1:0] rdata_r;

      // write port; contents are deliberately not reset
      always_ff @(posedge SPICLK) begin
        if (we) begin
          mem_r[wadr] <= wdata;
        end
      end

      // registered read returns pre-write data on a same-cycle collision
      always_ff @(posedge SPICLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
          rdata_r <= {DW{1'b0}};
        end else begin
          rdata_r <= mem_r[radr];
        end
      end

      assign rdata = rdata_r;
    end else begin : g_async_rd
      // write port; host writes are held off while reset is asserted
      always_ff @(posedge SPICLK) begin
        if (we && SYSRSTB) begin
          mem_r[wadr] <= wdata;
        end
      end

      assign rdata = mem_r[radr];
    end
  endgenerate

endmodule

// File: rtl/sc_spi_xfer_ctl.sv
// Multi-frame SPI transfer controller: owns the TX/RX word buffers and runs
// NFRM back-to-back frames through the engine's SPISTART/SPIBUSY handshake.
module sc_spi_xfer_ctl
  import sc_spi_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          SPICLK,
  input  logic          SYSRSTB,
  input  logic          BUFWE,
  input  logic [AW-1:0] BUFWADR,
  input  logic [31:0]   BUFWDATA,
  input  logic [AW-1:0] BUFRADR,
  output logic [31:0]   BUFRDATA,
  input  logic          XSTART,
  input  logic [AW-1:0] NFRM,
  input  logic          KEEPCS,
  output logic          XBUSY,
  output logic          XDONE,
  output logic          XERR,
  output logic [AW-1:0] FRMCNT,
  input  logic [8:0]    DWIDTH,
  output logic          SPISTART,
  input  logic          SPIBUSY,
  output logic          CSEXTEND,
  input  logic [3:0]    TXDPT,
  output logic [31:0]   TXDATA,
  input  logic [31:0]   RXDATA,
  input  logic          RXVALID,
  input  logic [3:0]    RXDPT
);

  localparam int unsigned BW = AW + 2;
  localparam logic [BW-1:0] LIM = BW'(DEPTH);
  localparam logic [AW-1:0] ONE_AW = AW'(1'b1);
  localparam logic [AW-1:0] ZERO_AW = {AW{1'b0}};

  xfer_state_e   state_r, state_s;
  logic [AW:0]   base_r;
  logic [AW-1:0] frmcnt_r;
  logic [AW-1:0] nfrm_r;
  logic          keepcs_r;
  logic          xerr_r;
  logic          xdone_r;
  logic          xbusy_r;
  logic          spistart_r;
  logic          csext_r;

  logic [4:0]    words_s;
  logic [BW-1:0] end_s;
  logic          overflow_s;
  logic [AW-1:0] frm_nx_s;
  logic          last_s;
  logic          penult_s;
  logic          accept_s;
  logic          zero_req_s;
  logic [AW-1:0] tx_radr_s;
  logic [AW-1:0] rx_wadr_s;

  assign words_s    = words_per_frame(DWIDTH);
  assign end_s      = {1'b0, base_r} + {{(BW-5){1'b0}}, words_s};
  assign overflow_s = (end_s > LIM);
  assign frm_nx_s   = frmcnt_r + ONE_AW;
  assign last_s     = (frm_nx_s == nfrm_r);
  assign penult_s   = (frm_nx_s == (nfrm_r - ONE_AW));
  assign accept_s   = (state_r == ST_IDLE) && XSTART && (NFRM != ZERO_AW);
  assign zero_req_s = (state_r == ST_IDLE) && XSTART && (NFRM == ZERO_AW);

  // window offset arithmetic wraps at AW bits; overflow is caught in CHK
  assign tx_radr_s = base_r[AW-1:0] + {{(AW-4){1'b0}}, TXDPT};
  assign rx_wadr_s = base_r[AW-1:0] + {{(AW-4){1'b0}}, RXDPT};

  // state register
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_CHK;
        else          state_s = ST_IDLE;
      end
      ST_CHK: begin
        if (overflow_s) state_s = ST_DONE;
        else            state_s = ST_START;
      end
      ST_START: state_s = ST_WBUSY;
      ST_WBUSY: begin
        if (SPIBUSY) state_s = ST_WIDLE;
        else         state_s = ST_WBUSY;
      end
      ST_WIDLE: begin
        if (!SPIBUSY) state_s = ST_GUARD;
        else          state_s = ST_WIDLE;
      end
      ST_GUARD: begin
        if (last_s) state_s = ST_DONE;
        else        state_s = ST_CHK;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // registered outputs and sequence bookkeeping
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      base_r     <= {(AW+1){1'b0}};
      frmcnt_r   <= ZERO_AW;
      nfrm_r     <= ZERO_AW;
      keepcs_r   <= 1'b0;
      xerr_r     <= 1'b0;
      xdone_r    <= 1'b0;
      xbusy_r    <= 1'b0;
      spistart_r <= 1'b0;
      csext_r    <= 1'b0;
    end else begin
      spistart_r <= (state_s == ST_START);
      xdone_r    <= (state_s == ST_DONE) || zero_req_s;
      xbusy_r    <= (state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            nfrm_r   <= NFRM;
            keepcs_r <= KEEPCS;
            base_r   <= {(AW+1){1'b0}};
            frmcnt_r <= ZERO_AW;
            xerr_r   <= 1'b0;
            if ((NFRM > ONE_AW) || KEEPCS) begin
              csext_r <= 1'b1;
            end
          end
        end
        ST_CHK: begin
          if (overflow_s) begin
            xerr_r <= 1'b1;
          end
        end
        ST_GUARD: begin
          frmcnt_r <= frm_nx_s;
          base_r   <= base_r + {{(AW-4){1'b0}}, words_s};
          // CS must drop with the final frame, so release it one guard early
          if (penult_s && !keepcs_r) begin
            csext_r <= 1'b0;
          end
        end
        ST_DONE: begin
          if (xerr_r && !keepcs_r) begin
            csext_r <= 1'b0;
          end
        end
        default: begin
          csext_r <= csext_r;
        end
      endcase
    end
  end

  sc_spi_bufram #(.DEPTH(DEPTH), .DW(WORD_W), .REG_RD(1'b0)) u_txbuf (
    .SPICLK  (SPICLK),
    .SYSRSTB (SYSRSTB),
    .we      (BUFWE),
    .wadr    (BUFWADR),
    .wdata   (BUFWDATA),
    .radr    (tx_radr_s),
    .rdata   (TXDATA)
  );

  sc_spi_bufram #(.DEPTH(DEPTH), .DW(WORD_W), .REG_RD(1'b1)) u_rxbuf (
    .SPICLK  (SPICLK),
    .SYSRSTB (SYSRSTB),
    .we      (RXVALID),
    .wadr    (rx_wadr_s),
    .wdata   (RXDATA),
    .radr    (BUFRADR),
    .rdata   (BUFRDATA)
  );

  assign XBUSY    = xbusy_r;
  assign XDONE    = xdone_r;
  assign XERR     = xerr_r;
  assign FRMCNT   = frmcnt_r;
  assign SPISTART = spistart_r;
  assign CSEXTEND = csext_r;

endmodule

// File: tb/tb_sc_spi_xfer_ctl.sv
// Directed bench for sc_spi_xfer_ctl with a small loopback SPI engine model.
module tb_sc_spi_xfer_ctl;

  logic        SPICLK = 1'b0;
  logic        SYSRSTB;
  logic        BUFWE;
  logic [5:0]  BUFWADR;
  logic [31:0] BUFWDATA;
  logic [5:0]  BUFRADR;
  logic [31:0] BUFRDATA;
  logic        XSTART;
  logic [5:0]  NFRM;
  logic        KEEPCS;
  logic        XBUSY, XDONE, XERR;
  logic [5:0]  FRMCNT;
  logic [8:0]  DWIDTH;
  logic        SPISTART;
  logic        SPIBUSY;
  logic        CSEXTEND;
  logic [3:0]  TXDPT;
  logic [31:0] TXDATA;
  logic [31:0] RXDATA;
  logic        RXVALID;
  logic [3:0]  RXDPT;

  int n_checks = 0;
  int n_errors = 0;

  sc_spi_xfer_ctl #(.DEPTH(64)) dut (
    .SPICLK(SPICLK), .SYSRSTB(SYSRSTB),
    .BUFWE(BUFWE), .BUFWADR(BUFWADR), .BUFWDATA(BUFWDATA),
    .BUFRADR(BUFRADR), .BUFRDATA(BUFRDATA),
    .XSTART(XSTART), .NFRM(NFRM), .KEEPCS(KEEPCS),
    .XBUSY(XBUSY), .XDONE(XDONE), .XERR(XERR), .FRMCNT(FRMCNT),
    .DWIDTH(DWIDTH), .SPISTART(SPISTART), .SPIBUSY(SPIBUSY),
    .CSEXTEND(CSEXTEND), .TXDPT(TXDPT), .TXDATA(TXDATA),
    .RXDATA(RXDATA), .RXVALID(RXVALID), .RXDPT(RXDPT)
  );

  always #5 SPICLK = ~SPICLK;

  int cyc = 0;
  always @(posedge SPICLK) cyc <= cyc + 1;

  // monitor: SPISTART pulses, CSEXTEND at each start, SPIBUSY falls, XDONE
  logic mon_clr = 1'b0;
  int   st_cnt, fall_cnt, xdone_cnt, xdone_cyc, cs_hi;
  int   start_arr [8];
  int   fall_arr  [8];
  logic cs_arr    [8];
  logic prev_busy;
  always @(negedge SPICLK) begin
    prev_busy <= SPIBUSY;
    if (mon_clr) begin
      st_cnt <= 0; fall_cnt <= 0; xdone_cnt <= 0; xdone_cyc <= 0; cs_hi <= 0;
    end else begin
      if (SPISTART === 1'b1) begin
        if (st_cnt < 8) begin
          start_arr[st_cnt] <= cyc;
          cs_arr[st_cnt]    <= CSEXTEND;
        end
        st_cnt <= st_cnt + 1;
      end
      if (prev_busy === 1'b1 && SPIBUSY === 1'b0) begin
        if (fall_cnt < 8) fall_arr[fall_cnt] <= cyc;
        fall_cnt <= fall_cnt + 1;
      end
      if (XDONE === 1'b1) begin
        xdone_cnt <= xdone_cnt + 1;
        xdone_cyc <= cyc;
      end
      if (CSEXTEND === 1'b1) cs_hi <= cs_hi + 1;
    end
  end

  // engine model: TX word i is read at TXDPT=i and looped back as RX word i
  bit          eng_active = 1'b0;
  int          eng_nw;
  logic [31:0] eng_cap;
  initial begin
    SPIBUSY = 1'b0; RXVALID = 1'b0; TXDPT = 4'd0; RXDPT = 4'd0; RXDATA = 32'd0;
    forever begin
      @(negedge SPICLK);
      if (SPISTART === 1'b1 && SYSRSTB === 1'b1) begin
        eng_nw = int'(DWIDTH[8:5]) + 1;
        eng_active = 1'b1;
        @(posedge SPICLK); #1;
        for (int i = 0; i < eng_nw; i++) begin
          SPIBUSY = 1'b1; RXVALID = 1'b0; TXDPT = 4'(i);
          @(negedge SPICLK); eng_cap = TXDATA;
          @(posedge SPICLK); #1;
          RXVALID = 1'b1; RXDPT = 4'(i); RXDATA = eng_cap;
          if (i == eng_nw - 1) SPIBUSY = 1'b0;
          @(posedge SPICLK); #1;
        end
        RXVALID = 1'b0;
        eng_active = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge SPICLK); #1;
  endtask

  task automatic clear_mon;
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
  endtask

  task automatic write_tx(input int adr, input logic [31:0] d);
    BUFWE = 1'b1; BUFWADR = 6'(adr); BUFWDATA = d;
    tick();
    BUFWE = 1'b0;
  endtask

  task automatic read_rx(input int adr, output logic [31:0] d);
    BUFRADR = 6'(adr);
    tick();
    d = BUFRDATA;
  endtask

  task automatic start_seq(input int nfrm, input logic keep, input logic [8:0] dw, output int c0);
    DWIDTH = dw; NFRM = 6'(nfrm); KEEPCS = keep; XSTART = 1'b1; c0 = cyc;
    tick();
    XSTART = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    k = 0;
    while (XDONE !== 1'b1 && k < budget) begin
      tick(); k++;
    end
    n_checks++;
    if (XDONE !== 1'b1) begin
      n_errors++; $display("FAIL %s_timeout: XDONE not seen within %0d cycles", nm, budget);
    end
  endtask

  task automatic test_reset;
    SYSRSTB = 1'b0; BUFWE = 1'b0; BUFWADR = 6'd0; BUFWDATA = 32'd0; BUFRADR = 6'd0;
    XSTART = 1'b0; NFRM = 6'd0; KEEPCS = 1'b0; DWIDTH = 9'd31;
    repeat (3) tick();
    n_checks++;
    if ({SPISTART, CSEXTEND, XBUSY, XDONE, XERR} !== 5'b0 || FRMCNT !== 6'd0 || BUFRDATA !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_vals: got st=%b cs=%b busy=%b done=%b err=%b frm=%0d rd=%h expected all zero",
               SPISTART, CSEXTEND, XBUSY, XDONE, XERR, FRMCNT, BUFRDATA);
    end
    SYSRSTB = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single;
    int c0;
    logic [31:0] d;
    write_tx(0, 32'hA5A5_1234);
    clear_mon();
    start_seq(1, 1'b0, 9'd31, c0);
    n_checks++;
    if (XBUSY !== 1'b1) begin n_errors++; $display("FAIL single_busy: got %b expected 1", XBUSY); end
    wait_done("single", 50);
    n_checks++;
    if (FRMCNT !== 6'd1 || XERR !== 1'b0) begin
      n_errors++; $display("FAIL single_frm: got frmcnt=%0d xerr=%b expected 1/0", FRMCNT, XERR);
    end
    tick();
    n_checks++;
    if (XBUSY !== 1'b0 || XDONE !== 1'b0) begin
      n_errors++; $display("FAIL single_end: got busy=%b done=%b expected 0/0", XBUSY, XDONE);
    end
    n_checks++;
    if (st_cnt != 1 || start_arr[0] != c0 + 2) begin
      n_errors++; $display("FAIL single_start: got %0d pulses at cyc %0d expected 1 at %0d", st_cnt, start_arr[0], c0 + 2);
    end
    n_checks++;
    if (xdone_cnt != 1 || xdone_cyc - fall_arr[0] != 2) begin
      n_errors++; $display("FAIL single_xdone: got cnt=%0d delay=%0d expected 1/2", xdone_cnt, xdone_cyc - fall_arr[0]);
    end
    n_checks++;
    if (cs_hi != 0) begin n_errors++; $display("FAIL single_cs: got %0d high cycles expected 0", cs_hi); end
    read_rx(0, d);
    n_checks++;
    if (d !== 32'hA5A5_1234) begin n_errors++; $display("FAIL single_rx: got %h expected a5a51234", d); end
  endtask

  task automatic test_multi;
    int c0;
    logic [31:0] d;
    for (int i = 0; i < 6; i++) write_tx(i, 32'h1000_0000 + 32'(i * 17));
    clear_mon();
    start_seq(3, 1'b0, 9'd63, c0);
    repeat (6) tick();
    NFRM = 6'd1; KEEPCS = 1'b1; XSTART = 1'b1;
    tick();
    XSTART = 1'b0; KEEPCS = 1'b0;
    wait_done("multi", 100);
    n_checks++;
    if (FRMCNT !== 6'd3) begin n_errors++; $display("FAIL multi_frmcnt: got %0d expected 3", FRMCNT); end
    tick();
    n_checks++;
    if (st_cnt != 3) begin n_errors++; $display("FAIL multi_starts: got %0d expected 3", st_cnt); end
    n_checks++;
    if (cs_arr[0] !== 1'b1 || cs_arr[1] !== 1'b1 || cs_arr[2] !== 1'b0) begin
      n_errors++; $display("FAIL multi_cs: got %b%b%b expected 110", cs_arr[0], cs_arr[1], cs_arr[2]);
    end
    n_checks++;
    if (start_arr[1] - fall_arr[0] != 3) begin
      n_errors++; $display("FAIL multi_gap: got %0d expected 3", start_arr[1] - fall_arr[0]);
    end
    for (int i = 0; i < 6; i++) begin
      read_rx(i, d);
      n_checks++;
      if (d !== 32'h1000_0000 + 32'(i * 17)) begin
        n_errors++; $display("FAIL multi_rx%0d: got %h expected %h", i, d, 32'h1000_0000 + 32'(i * 17));
      end
    end
  endtask

  task automatic test_overflow;
    int c0;
    clear_mon();
    start_seq(5, 1'b0, 9'd511, c0);
    wait_done("ovf", 400);
    n_checks++;
    if (XERR !== 1'b1 || FRMCNT !== 6'd4) begin
      n_errors++; $display("FAIL ovf_err: got xerr=%b frmcnt=%0d expected 1/4", XERR, FRMCNT);
    end
    tick();
    n_checks++;
    if (st_cnt != 4 || xdone_cnt != 1 || CSEXTEND !== 1'b0) begin
      n_errors++; $display("FAIL ovf_seq: got starts=%0d dones=%0d cs=%b expected 4/1/0", st_cnt, xdone_cnt, CSEXTEND);
    end
  endtask

  task automatic test_nfrm0;
    int c0;
    clear_mon();
    start_seq(0, 1'b0, 9'd31, c0);
    n_checks++;
    if (XDONE !== 1'b1 || XBUSY !== 1'b0) begin
      n_errors++; $display("FAIL zero_done: got done=%b busy=%b expected 1/0", XDONE, XBUSY);
    end
    tick();
    n_checks++;
    if (XDONE !== 1'b0) begin n_errors++; $display("FAIL zero_pulse: got %b expected 0", XDONE); end
    repeat (5) tick();
    n_checks++;
    if (st_cnt != 0 || XERR !== 1'b1) begin
      n_errors++; $display("FAIL zero_idle: got starts=%0d xerr=%b expected 0/1", st_cnt, XERR);
    end
  endtask

  task automatic test_keepcs;
    int c0;
    clear_mon();
    start_seq(1, 1'b1, 9'd31, c0);
    wait_done("keep1", 50);
    n_checks++;
    if (XERR !== 1'b0) begin n_errors++; $display("FAIL keep_xerr: got %b expected 0", XERR); end
    repeat (4) tick();
    n_checks++;
    if (CSEXTEND !== 1'b1 || cs_arr[0] !== 1'b1) begin
      n_errors++; $display("FAIL keep_hold: got cs=%b at_start=%b expected 1/1", CSEXTEND, cs_arr[0]);
    end
    clear_mon();
    start_seq(2, 1'b0, 9'd31, c0);
    wait_done("keep2", 80);
    tick();
    n_checks++;
    if (CSEXTEND !== 1'b0 || cs_arr[0] !== 1'b1 || cs_arr[1] !== 1'b0) begin
      n_errors++; $display("FAIL keep_drop: got cs=%b starts=%b%b expected 0/10", CSEXTEND, cs_arr[0], cs_arr[1]);
    end
  endtask

  task automatic test_reset_mid;
    int c0, k;
    logic [31:0] d;
    write_tx(0, 32'h1357_9BDF);
    start_seq(2, 1'b0, 9'd511, c0);
    k = 0;
    while (SPIBUSY !== 1'b1 && k < 20) begin tick(); k++; end
    repeat (3) tick();
    n_checks++;
    if (XBUSY !== 1'b1 || CSEXTEND !== 1'b1) begin
      n_errors++; $display("FAIL rmid_pre: got busy=%b cs=%b expected 1/1", XBUSY, CSEXTEND);
    end
    SYSRSTB = 1'b0; #1;
    n_checks++;
    if ({SPISTART, CSEXTEND, XBUSY, XDONE, XERR} !== 5'b0 || FRMCNT !== 6'd0 || BUFRDATA !== 32'd0) begin
      n_errors++; $display("FAIL rmid_vals: got st=%b cs=%b busy=%b done=%b err=%b frm=%0d expected zeros",
                           SPISTART, CSEXTEND, XBUSY, XDONE, XERR, FRMCNT);
    end
    tick();
    SYSRSTB = 1'b1;
    k = 0;
    while (eng_active && k < 100) begin tick(); k++; end
    clear_mon();
    start_seq(1, 1'b0, 9'd31, c0);
    wait_done("rmid", 50);
    n_checks++;
    if (FRMCNT !== 6'd1 || XERR !== 1'b0) begin
      n_errors++; $display("FAIL rmid_frm: got frmcnt=%0d xerr=%b expected 1/0", FRMCNT, XERR);
    end
    tick();
    read_rx(0, d);
    n_checks++;
    if (d !== 32'h1357_9BDF || st_cnt != 1) begin
      n_errors++; $display("FAIL rmid_rx: got %h starts=%0d expected 13579bdf/1", d, st_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_overflow();
    test_nfrm0();
    test_keepcs();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sc_spi_xfer_ctl.md
# sc_spi_xfer_ctl

Multi-frame transfer controller that sits directly upstream of the SPI protocol controller, `sc_spi_spc`, in the SPI engine. It owns the TX and RX word buffers, sequences N back-to-back SPI frames through the engine's SPISTART/SPIBUSY handshake, and drives CSEXTEND so chip select stays asserted across frames. It serves TXDATA by the engine's TXDPT and stores RXDATA by RXDPT. Each frame has its own buffer window.

## Interface
- DEPTH, 64: words per buffer (TX and RX each); power of two, 16..256; AW = clog2(DEPTH)
- SPICLK  in  1  clock (same clock as the engine)
- SYSRSTB  in  1  asynchronous, active-low reset
- BUFWE  in  1  host TX-buffer write strobe
- BUFWADR  in  AW  host TX-buffer write address
- BUFWDATA  in  32  host TX-buffer write data
- BUFRADR  in  AW  host RX-buffer read address
- BUFRDATA  out  32  RX-buffer read data, registered, 1-cycle latency
- XSTART  in  1  start-sequence pulse
- NFRM  in  AW  number of frames; 0 = no transfer
- KEEPCS  in  1  keep CS asserted after the last frame
- XBUSY  out  1  sequence in progress
- XDONE  out  1  one-cycle completion pulse
- XERR  out  1  buffer-overflow abort; sticky until the next accepted XSTART
- FRMCNT  out  AW  frames completed in the current/last sequence
- DWIDTH  in  9  frame width minus 1 (same value the engine receives)
- SPISTART  out  1  frame start to the engine
- SPIBUSY  in  1  engine busy
- CSEXTEND  out  1  CS extend to the engine
- TXDPT  in  4  engine TX word pointer
- TXDATA  out  32  TX word, combinational read of txmem[base+TXDPT]
- RXDATA  in  32  engine RX word
- RXVALID  in  1  engine RX word valid
- RXDPT  in  4  engine RX word pointer

## Operation
- Words per frame: W = DWIDTH[8:5] + 1 (1..16). Frame k uses window base = k*W.
- base is an AW+1-bit register, so the overflow compare base+W > DEPTH is exact.
- RX write: on every RXVALID, regardless of state, rxmem[base+RXDPT] <= RXDATA. Address arithmetic is AW bits.
- TX read is asynchronous (distributed RAM). A host write to the word currently addressed by TXDPT is visible on TXDATA in the next cycle.
- A host RX read of a word written in the same cycle returns the old data.
- Memories are not reset.
- The FSM is Moore with one-hot or binary encoding; outputs decode from registered state. States and transitions:
  - IDLE: XSTART with NFRM != 0 latches NFRM and KEEPCS, clears base, FRMCNT and XERR, sets XBUSY, then goes to CHK. XSTART with NFRM == 0 pulses XDONE next cycle and stays in IDLE. XSTART while XBUSY=1 is ignored.
  - CHK: if base+W > DEPTH, set XERR and go to DONE; else go to START.
  - START: SPISTART=1 for exactly this cycle, then go to WBUSY.
  - WBUSY: wait for SPIBUSY=1, then go to WIDLE.
  - WIDLE: wait for SPIBUSY=0, then go to GUARD.
  - GUARD: one cycle; FRMCNT+1 and base += W. If FRMCNT+1 == NFRM go to DONE, else go to CHK.
  - DONE: XDONE=1; XBUSY clears at the end of this cycle; go to IDLE.
- CSEXTEND is registered:
  - Set on XSTART acceptance when NFRM > 1 or KEEPCS.
  - Cleared in GUARD of the second-to-last frame unless KEEPCS was latched.
  - Cleared in DONE on XERR unless KEEPCS was latched.
  - Otherwise held, including across IDLE after a KEEPCS sequence, until a later sequence clears it.

## Timing
- Reset values: SPISTART 0, CSEXTEND 0, XBUSY 0, XDONE 0, XERR 0, FRMCNT 0, BUFRDATA 0; state IDLE, base 0.
- XSTART sampled at edge 0 → CHK in cycle 1, SPISTART high in cycle 2, engine SPIBUSY high from cycle 3.
- Inter-frame gap, from SPIBUSY low to the next SPISTART: 3 cycles (GUARD, CHK, START).
- The engine's last RXVALID coincides with the first SPIBUSY-low cycle. That write still uses the old base, because base updates at the end of GUARD.
- XDONE fires 2 cycles after SPIBUSY falls on the last frame.
- Reset mid-sequence: immediate return to reset values. The engine is reset by the same SYSRSTB.

## Structure
- sc_spi_pkg holds the FSM state encodings.
- One sub-module, sc_spi_bufram: 1W/1R dual-port memory with a parameterised read style (async/registered), instantiated once for TX and once for RX.

## Test plan
- DWIDTH=31, NFRM=1, KEEPCS=0, txmem[0]=0xA5A5_1234 → one SPISTART pulse; rxmem[0]=looped MISO word; XDONE 2 cycles after SPIBUSY falls; CSEXTEND never high.
- DWIDTH=63, NFRM=3 → windows 0,2,4; CSEXTEND high through frames 0-1, low before frame 2's SPISTART; FRMCNT=3.
- DEPTH=64, DWIDTH=511 (W=16), NFRM=5 → 4 frames run, then XERR=1, FRMCNT=4, XDONE pulses, CSEXTEND low.
- NFRM=0 → XDONE one cycle after XSTART; SPISTART never asserts.
- KEEPCS=1, NFRM=1 → CSEXTEND stays high after XDONE; a second XSTART with KEEPCS=0 drops it at that sequence's end.
- SYSRSTB low while in WIDLE → all outputs return to reset values; XSTART after release starts cleanly from base 0.
